a3x8_pulse_decoder: RTL and testbench



---
 rtl/a3x8_pkg.sv | 17 +
 rtl/a3x8_pulse_decoder_if.sv | 19 +
 rtl/a3x8_decoder.sv | 20 ++
 rtl/a3x8_pulse_decoder.sv | 143 ++++++++++++++
 tb/tb_a3x8_pulse_decoder.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/a3x8_pkg.sv
// a3x8_pkg
// Shared definitions for the 3-to-8 pulse decoder slice: code/output widths
// and the FSM state encoding used by a3x8_pulse_decoder.
// No ports (package).

package a3x8_pkg;

  localparam int CODE_W = 3;
  localparam int OUT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/a3x8_pulse_decoder_if.sv
// a3x8_pulse_decoder_if
// Code handshake between a code producer and the pulse decoder.
// Signals:
//   code       [2:0] code to decode
//   code_valid        producer presents a code
//   code_ready        decoder can accept a code
// Modports: master (producer side), slave (decoder side).

interface a3x8_pulse_decoder_if;
  import a3x8_pkg::*;

  logic [CODE_W-1:0] code;
  logic              code_valid;
  logic              code_ready;

  modport master (output code, output code_valid, input  code_ready);
  modport slave  (input  code, input  code_valid, output code_ready);

endinterface

// File: rtl/a3x8_decoder.sv
// a3x8_decoder
// Combinational 3-to-8 one-hot decoder, the exact inverse of the 8-to-3
// one-hot encoder: d = n drives onehot[n] and nothing else.
// Ports:
//   d      in  [2:0] binary code
//   onehot out [7:0] one-hot word

module a3x8_decoder
  import a3x8_pkg::*;
(
  input  logic [CODE_W-1:0] d,
  output logic [OUT_W-1:0]  onehot
);

  always_comb begin
    onehot    = '0;
    onehot[d] = 1'b1;
  end

endmodule

// File: rtl/a3x8_pulse_decoder.sv
// a3x8_pulse_decoder
// Sequential 3-to-8 decoder. Accepts codes over a valid/ready handshake into
// a one-entry pending register, then drives y[code] for HOLD_CYCLES clocks
// followed by GAP_CYCLES all-zero clocks.
// Ports:
//   clk    in       rising-edge clock
//   rst_n  in       asynchronous active-low reset
//   cif    slave    code / code_valid / code_ready handshake
//   en     in       output enable, masks y only (timing unaffected)
//   y      out [7:0] one-hot or zero output word
//   busy   out      pending code held or FSM not idle
//   done   out      one-clock pulse after each hold word completes

module a3x8_pulse_decoder
  import a3x8_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  a3x8_pulse_decoder_if.slave     cif,
  input  logic                    en,
  output logic [OUT_W-1:0]        y,
  output logic                    busy,
  output logic                    done
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [OUT_W-1:0]   y_reg, y_next;
  logic [OUT_W-1:0]   pend_onehot;
  logic [CODE_W-1:0]  pend_code;
  logic               pend_valid, pend_valid_next;
  logic               done_next;
  logic               accept;
  logic               consume;

  a3x8_decoder u_decoder (
    .d      (pend_code),
    .onehot (pend_onehot)
  );

  // Pending slot is empty whenever ready; accept and consume are therefore
  // mutually exclusive, so no accept can happen on the consuming edge.
  assign cif.code_ready = !pend_valid;
  assign accept         = cif.code_valid && cif.code_ready;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    y_next     = y_reg;
    done_next  = 1'b0;
    consume    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (pend_valid) begin
          state_next = ST_HOLD;
          y_next     = pend_onehot;
          cnt_next   = HOLD_LOAD;
          consume    = 1'b1;
        end
      end

      ST_HOLD: begin
        if (cnt != '0) begin
          cnt_next = cnt - CNT_ONE;
        end else begin
          // Last clock of the word: done registers high on the leaving edge.
          done_next = 1'b1;
          if (GAP_CYCLES > 0) begin
            state_next = ST_GAP;
            y_next     = '0;
            cnt_next   = GAP_LOAD;
          end else if (pend_valid) begin
            y_next   = pend_onehot;
            cnt_next = HOLD_LOAD;
            consume  = 1'b1;
          end else begin
            state_next = ST_IDLE;
            y_next     = '0;
          end
        end
      end

      ST_GAP: begin
        if (cnt != '0) begin
          cnt_next = cnt - CNT_ONE;
        end else if (pend_valid) begin
          state_next = ST_HOLD;
          y_next     = pend_onehot;
          cnt_next   = HOLD_LOAD;
          consume    = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
        y_next     = '0;
        cnt_next   = '0;
      end
    endcase

    pend_valid_next = pend_valid;
    if (consume) begin
      pend_valid_next = 1'b0;
    end else if (accept) begin
      pend_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      y_reg      <= '0;
      done       <= 1'b0;
      pend_valid <= 1'b0;
      pend_code  <= '0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      y_reg      <= y_next;
      done       <= done_next;
      pend_valid <= pend_valid_next;
      if (accept) begin
        pend_code <= cif.code;
      end
    end
  end

  assign y    = y_reg & {OUT_W{en}};
  assign busy = (state != ST_IDLE) || pend_valid;

endmodule

// File: tb/tb_a3x8_pulse_decoder.sv
// tb_a3x8_pulse_decoder
// Directed bench for a3x8_pulse_decoder: instance A uses HOLD=4/GAP=1,
// instance B uses HOLD=4/GAP=0. Outputs are sampled 1 time unit after each
// rising edge; inputs are changed at that same point for the next edge.

module tb_a3x8_pulse_decoder;

  logic       clk;
  logic       rst_n;
  logic       a_en, b_en;
  logic [7:0] a_y, b_y;
  logic       a_busy, b_busy;
  logic       a_done, b_done;

  int checks = 0;
  int errors = 0;

  a3x8_pulse_decoder_if a_if ();
  a3x8_pulse_decoder_if b_if ();

  a3x8_pulse_decoder #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .cif   (a_if),
    .en    (a_en),
    .y     (a_y),
    .busy  (a_busy),
    .done  (a_done)
  );

  a3x8_pulse_decoder #(.HOLD_CYCLES(4), .GAP_CYCLES(0), .CNT_W(8)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .cif   (b_if),
    .en    (b_en),
    .y     (b_y),
    .busy  (b_busy),
    .done  (b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [7:0] ey, input logic ed,
                       input logic eb, input logic er);
    check_output({tag, ".a.y"},     a_y,                   ey);
    check_output({tag, ".a.done"},  {7'd0, a_done},        {7'd0, ed});
    check_output({tag, ".a.busy"},  {7'd0, a_busy},        {7'd0, eb});
    check_output({tag, ".a.ready"}, {7'd0, a_if.code_ready}, {7'd0, er});
  endtask

  task automatic chk_b(input string tag, input logic [7:0] ey, input logic ed,
                       input logic eb, input logic er);
    check_output({tag, ".b.y"},     b_y,                   ey);
    check_output({tag, ".b.done"},  {7'd0, b_done},        {7'd0, ed});
    check_output({tag, ".b.busy"},  {7'd0, b_busy},        {7'd0, eb});
    check_output({tag, ".b.ready"}, {7'd0, b_if.code_ready}, {7'd0, er});
  endtask

  task automatic apply_stimulus_a(input logic [2:0] c, input logic v);
    a_if.code       = c;
    a_if.code_valid = v;
  endtask

  task automatic apply_stimulus_b(input logic [2:0] c, input logic v);
    b_if.code       = c;
    b_if.code_valid = v;
  endtask

  initial begin
    rst_n = 1'b0;
    a_en  = 1'b1;
    b_en  = 1'b1;
    apply_stimulus_a(3'd0, 1'b0);
    apply_stimulus_b(3'd0, 1'b0);

    // Reset state, before any clock edge
    #2;
    chk_a("rst", 8'h00, 1'b0, 1'b0, 1'b1);
    chk_b("rst", 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();
    chk_a("idle", 8'h00, 1'b0, 1'b0, 1'b1);

    // Single code 5 on A: hold 4, gap 1 with done, then idle
    apply_stimulus_a(3'd5, 1'b1);
    tick();                                   // edge k: accept
    apply_stimulus_a(3'd5, 1'b0);
    chk_a("c5.k0", 8'h00, 1'b0, 1'b1, 1'b0);
    tick(); chk_a("c5.k1", 8'h20, 1'b0, 1'b1, 1'b1);
    tick(); chk_a("c5.k2", 8'h20, 1'b0, 1'b1, 1'b1);
    tick(); chk_a("c5.k3", 8'h20, 1'b0, 1'b1, 1'b1);
    tick(); chk_a("c5.k4", 8'h20, 1'b0, 1'b1, 1'b1);
    tick(); chk_a("c5.k5", 8'h00, 1'b1, 1'b1, 1'b1);
    tick(); chk_a("c5.k6", 8'h00, 1'b0, 1'b0, 1'b1);

    // Codes 0 then 7 with code_valid held
    apply_stimulus_a(3'd0, 1'b1);
    tick();                                   // k: accept 0
    apply_stimulus_a(3'd7, 1'b1);
    chk_a("c07.k0", 8'h00, 1'b0, 1'b1, 1'b0);
    tick(); chk_a("c07.k1", 8'h01, 1'b0, 1'b1, 1'b1);
    tick();                                   // k+2: accept 7
    apply_stimulus_a(3'd7, 1'b0);
    chk_a("c07.k2", 8'h01, 1'b0, 1'b1, 1'b0);
    tick(); chk_a("c07.k3", 8'h01, 1'b0, 1'b1, 1'b0);
    tick(); chk_a("c07.k4", 8'h01, 1'b0, 1'b1, 1'b0);
    tick(); chk_a("c07.k5", 8'h00, 1'b1, 1'b1, 1'b0);
    tick(); chk_a("c07.k6", 8'h80, 1'b0, 1'b1, 1'b1);
    tick(); chk_a("c07.k7", 8'h80, 1'b0, 1'b1, 1'b1);
    tick(); chk_a("c07.k8", 8'h80, 1'b0, 1'b1, 1'b1);
    tick(); chk_a("c07.k9", 8'h80, 1'b0, 1'b1, 1'b1);
    tick(); chk_a("c07.k10", 8'h00, 1'b1, 1'b1, 1'b1);
    tick(); chk_a("c07.k11", 8'h00, 1'b0, 1'b0, 1'b1);

    // Code 2 with en low during 2nd and 3rd hold clocks
    apply_stimulus_a(3'd2, 1'b1);
    tick();
    apply_stimulus_a(3'd2, 1'b0);
    tick(); chk_a("en.k1", 8'h04, 1'b0, 1'b1, 1'b1);
    a_en = 1'b0;
    tick(); chk_a("en.k2", 8'h00, 1'b0, 1'b1, 1'b1);
    tick(); chk_a("en.k3", 8'h00, 1'b0, 1'b1, 1'b1);
    a_en = 1'b1;
    tick(); chk_a("en.k4", 8'h04, 1'b0, 1'b1, 1'b1);
    tick(); chk_a("en.k5", 8'h00, 1'b1, 1'b1, 1'b1);
    tick(); chk_a("en.k6", 8'h00, 1'b0, 1'b0, 1'b1);

    // Async reset in the 2nd hold clock with a pending code
    apply_stimulus_a(3'd3, 1'b1);
    tick();                                   // accept 3
    apply_stimulus_a(3'd6, 1'b1);
    tick(); chk_a("mr.k1", 8'h08, 1'b0, 1'b1, 1'b1);
    tick();                                   // accept 6, 2nd hold clock
    apply_stimulus_a(3'd6, 1'b0);
    chk_a("mr.k2", 8'h08, 1'b0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_a("mr.async", 8'h00, 1'b0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b1;
    tick(); chk_a("mr.after1", 8'h00, 1'b0, 1'b0, 1'b1);
    tick(); chk_a("mr.after2", 8'h00, 1'b0, 1'b0, 1'b1);
    tick(); chk_a("mr.after3", 8'h00, 1'b0, 1'b0, 1'b1);
    apply_stimulus_a(3'd4, 1'b1);
    tick();
    apply_stimulus_a(3'd4, 1'b0);
    tick(); chk_a("mr.new", 8'h10, 1'b0, 1'b1, 1'b1);

    // GAP_CYCLES=0 instance: codes 1 then 2 back-to-back
    apply_stimulus_b(3'd1, 1'b1);
    tick();                                   // k: accept 1
    apply_stimulus_b(3'd2, 1'b1);
    chk_b("g0.k0", 8'h00, 1'b0, 1'b1, 1'b0);
    tick(); chk_b("g0.k1", 8'h02, 1'b0, 1'b1, 1'b1);
    tick();                                   // k+2: accept 2
    apply_stimulus_b(3'd2, 1'b0);
    chk_b("g0.k2", 8'h02, 1'b0, 1'b1, 1'b0);
    tick(); chk_b("g0.k3", 8'h02, 1'b0, 1'b1, 1'b0);
    tick(); chk_b("g0.k4", 8'h02, 1'b0, 1'b1, 1'b0);
    tick(); chk_b("g0.k5", 8'h04, 1'b1, 1'b1, 1'b1);
    tick(); chk_b("g0.k6", 8'h04, 1'b0, 1'b1, 1'b1);
    tick(); chk_b("g0.k7", 8'h04, 1'b0, 1'b1, 1'b1);
    tick(); chk_b("g0.k8", 8'h04, 1'b0, 1'b1, 1'b1);
    tick(); chk_b("g0.k9", 8'h00, 1'b1, 1'b0, 1'b1);
    tick(); chk_b("g0.k10", 8'h00, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
